// File: rtl/calc_result_transmitter.sv
// Serial result transmitter: captures a parallel word on TransferData and shifts it
// out MSB-first, holding each bit CYCLES_PER_BIT clocks, then pulses TransferDone.
module calc_result_transmitter #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned CYCLES_PER_BIT = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             TransferData,
  input  logic [WIDTH-1:0] DataIn,
  output logic             SerialOut,
  output logic             OutValid,
  output logic             TxBusy,
  output logic             TransferDone
);

  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CYC_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               serial_q, serial_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // State, datapath and output registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      cyc_q    <= '0;
      serial_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      cyc_q    <= cyc_d;
      serial_q <= serial_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register in step
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    cyc_d    = cyc_q;
    serial_d = 1'b0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (TransferData) begin
          shift_d = DataIn;
          bit_d   = BIT_W'(WIDTH - 1);
          cyc_d   = CYC_W'(CYCLES_PER_BIT - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cyc_q != '0) begin
          cyc_d = cyc_q - CYC_W'(1);
        end else if (bit_q != '0) begin
          shift_d = shift_q << 1;
          bit_d   = bit_q - BIT_W'(1);
          cyc_d   = CYC_W'(CYCLES_PER_BIT - 1);
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      SHIFT: begin
        serial_d = shift_d[WIDTH-1];
        valid_d  = 1'b1;
        busy_d   = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign SerialOut    = serial_q;
  assign OutValid     = valid_q;
  assign TxBusy       = busy_q;
  assign TransferDone = done_q;

endmodule
